// File: rtl/gpio_defaults_pkg.sv
// Shared types and constants for the GPIO defaults serial loader.
package gpio_defaults_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } load_state_e;

    localparam logic [12:0] DEFAULT_WORD = 13'h0402;

endpackage

// File: rtl/gpio_serial_phase_gen.sv
// Divides clk into serial_clock phases of HALF_PERIOD cycles and flags the last
// cycle of each phase.
module gpio_serial_phase_gen #(
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic high_phase,
    output logic phase_tick,
    output logic serial_clock
);

    localparam int unsigned PW = $clog2(HALF_PERIOD + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(HALF_PERIOD - 1);

    logic [PW-1:0] phase_q, phase_d;

    assign phase_tick   = run && (phase_q == LAST_PHASE);
    assign serial_clock = run && high_phase;

    // Counter restarts at every phase boundary and idles at zero outside a shift.
    always_comb begin
        phase_d = '0;
        if (run && !phase_tick) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/gpio_defaults_loader.sv
// Holds per-channel GPIO default words and shifts them out over a serial chain,
// automatically after reset and on request.
module gpio_defaults_loader
    import gpio_defaults_pkg::*;
#(
    parameter int unsigned                   NUM_GPIO         = 19,
    parameter int unsigned                   CFG_WIDTH        = 13,
    parameter logic [NUM_GPIO*CFG_WIDTH-1:0] GPIO_CONFIG_INIT = {NUM_GPIO{DEFAULT_WORD}},
    parameter int unsigned                   HALF_PERIOD      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_req,
    input  logic                          ovr_we,
    input  logic [$clog2(NUM_GPIO)-1:0]   ovr_idx,
    input  logic [CFG_WIDTH-1:0]          ovr_data,
    output logic [NUM_GPIO*CFG_WIDTH-1:0] gpio_defaults,
    output logic                          serial_clock,
    output logic                          serial_data,
    output logic                          serial_load,
    output logic                          busy,
    output logic                          done,
    output logic                          ovr_err
);

    localparam int unsigned TOTAL = NUM_GPIO * CFG_WIDTH;
    localparam int unsigned BW    = $clog2(TOTAL + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(TOTAL - 1);

    load_state_e        state_q, state_d;
    logic               auto_q, auto_d;
    logic [TOTAL-1:0]   gpio_q, gpio_d;
    logic [TOTAL-1:0]   shift_q, shift_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic               err_q, err_d;
    logic               shifting;
    logic               phase_tick;
    logic               wr_open;
    logic               idx_ok;

    assign shifting = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);

    gpio_serial_phase_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_phase_gen (
        .clk          (clk),
        .reset        (reset),
        .run          (shifting),
        .high_phase   (state_q == SHIFT_HI),
        .phase_tick   (phase_tick),
        .serial_clock (serial_clock)
    );

    // auto_q requests the power-on load in the first cycle after reset.
    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (auto_q || load_req) begin
                    state_d = SHIFT_LO;
                    auto_d  = 1'b0;
                    shift_d = gpio_q;
                    bit_d   = '0;
                end
            end
            SHIFT_LO: begin
                if (phase_tick) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = LATCH;
                    end else begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q << 1;
                    end
                end
            end
            LATCH: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                bit_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_open = (state_q == IDLE) || (state_q == DONE);
    assign idx_ok  = 32'(ovr_idx) < NUM_GPIO;

    always_comb begin
        gpio_d = gpio_q;
        err_d  = 1'b0;
        if (ovr_we) begin
            if (wr_open && idx_ok) begin
                for (int unsigned k = 0; k < NUM_GPIO; k++) begin
                    if (32'(ovr_idx) == k) begin
                        gpio_d[k*CFG_WIDTH +: CFG_WIDTH] = ovr_data;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            auto_q  <= 1'b1;
            gpio_q  <= GPIO_CONFIG_INIT;
            shift_q <= '0;
            bit_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            gpio_q  <= gpio_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
        end
    end

    assign gpio_defaults = gpio_q;
    assign serial_data   = shifting && shift_q[TOTAL-1];
    assign serial_load   = (state_q == LATCH);
    assign busy          = shifting || (state_q == LATCH);
    assign done          = (state_q == DONE);
    assign ovr_err       = err_q;

endmodule

// File: tb/tb_gpio_defaults_loader.sv
// Directed bench: power-on load, overrides, rejected writes, mid-load reset,
// slow serial clock and out-of-range channel index.
module tb_gpio_defaults_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [25:0] A_INIT = {13'h1803, 13'h0402};
    localparam logic [25:0] B_INIT = {13'h0402, 13'h0402};
    localparam logic [38:0] C_INIT = {3{13'h0402}};

    // Instance A: 2 channels, HALF_PERIOD=1
    logic        a_reset, a_load_req, a_ovr_we;
    logic [0:0]  a_ovr_idx;
    logic [12:0] a_ovr_data;
    logic [25:0] a_gpio;
    logic        a_sc, a_sd, a_sl, a_busy, a_done, a_err;

    gpio_defaults_loader #(
        .NUM_GPIO (2), .CFG_WIDTH (13), .GPIO_CONFIG_INIT (A_INIT), .HALF_PERIOD (1)
    ) u_a (
        .clk (clk), .reset (a_reset), .load_req (a_load_req), .ovr_we (a_ovr_we),
        .ovr_idx (a_ovr_idx), .ovr_data (a_ovr_data), .gpio_defaults (a_gpio),
        .serial_clock (a_sc), .serial_data (a_sd), .serial_load (a_sl),
        .busy (a_busy), .done (a_done), .ovr_err (a_err)
    );

    // Instance B: 2 channels, HALF_PERIOD=3
    logic        b_reset, b_load_req, b_ovr_we;
    logic [0:0]  b_ovr_idx;
    logic [12:0] b_ovr_data;
    logic [25:0] b_gpio;
    logic        b_sc, b_sd, b_sl, b_busy, b_done, b_err;

    gpio_defaults_loader #(
        .NUM_GPIO (2), .CFG_WIDTH (13), .GPIO_CONFIG_INIT (B_INIT), .HALF_PERIOD (3)
    ) u_b (
        .clk (clk), .reset (b_reset), .load_req (b_load_req), .ovr_we (b_ovr_we),
        .ovr_idx (b_ovr_idx), .ovr_data (b_ovr_data), .gpio_defaults (b_gpio),
        .serial_clock (b_sc), .serial_data (b_sd), .serial_load (b_sl),
        .busy (b_busy), .done (b_done), .ovr_err (b_err)
    );

    // Instance C: 3 channels, so an out-of-range index is representable
    logic        c_reset, c_load_req, c_ovr_we;
    logic [1:0]  c_ovr_idx;
    logic [12:0] c_ovr_data;
    logic [38:0] c_gpio;
    logic        c_sc, c_sd, c_sl, c_busy, c_done, c_err;

    gpio_defaults_loader #(
        .NUM_GPIO (3), .CFG_WIDTH (13), .GPIO_CONFIG_INIT (C_INIT), .HALF_PERIOD (1)
    ) u_c (
        .clk (clk), .reset (c_reset), .load_req (c_load_req), .ovr_we (c_ovr_we),
        .ovr_idx (c_ovr_idx), .ovr_data (c_ovr_data), .gpio_defaults (c_gpio),
        .serial_clock (c_sc), .serial_data (c_sd), .serial_load (c_sl),
        .busy (c_busy), .done (c_done), .ovr_err (c_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs A until done (bounded), capturing bits on serial_clock rising edges.
    task automatic collect_a(output logic [25:0] stream, output int busy_n,
                             output int load_at, output int done_at, output int bits);
        bit prev = 1'b0;
        int t = 0;
        stream = '0; busy_n = 0; load_at = -1; done_at = -1; bits = 0;
        while (done_at < 0 && t < 300) begin
            step();
            t++;
            a_load_req = 1'b0;
            a_ovr_we   = 1'b0;
            if (a_busy) busy_n++;
            if (a_sc && !prev) begin
                stream = {stream[24:0], a_sd};
                bits++;
            end
            prev = a_sc;
            if (a_sl) load_at = t;
            if (a_done) done_at = t;
        end
    endtask

    initial begin
        logic [25:0] stream;
        int busy_n, load_at, done_at, bits;
        int seen, sl_seen;

        a_reset = 1'b1; a_load_req = 1'b0; a_ovr_we = 1'b0; a_ovr_idx = '0; a_ovr_data = '0;
        b_reset = 1'b1; b_load_req = 1'b0; b_ovr_we = 1'b0; b_ovr_idx = '0; b_ovr_data = '0;
        c_reset = 1'b1; c_load_req = 1'b0; c_ovr_we = 1'b0; c_ovr_idx = '0; c_ovr_data = '0;
        repeat (3) step();

        chk("reset_outputs", {a_busy, a_sc, a_sd, a_sl, a_done, a_err}, 6'b0);
        chk("reset_gpio", a_gpio, A_INIT);

        // Power-on load
        a_reset = 1'b0;
        collect_a(stream, busy_n, load_at, done_at, bits);
        chk("pon_stream", stream, {13'h1803, 13'h0402});
        chk("pon_bits", bits, 26);
        chk("pon_busy_cycles", busy_n, 53);
        chk("pon_load_cycle", load_at, 53);
        chk("pon_done_cycle", done_at, 54);

        // Override written in the DONE cycle, then explicit reload
        a_ovr_we = 1'b1; a_ovr_idx = 1'b0; a_ovr_data = 13'h1FFF;
        step();
        a_ovr_we = 1'b0;
        chk("ovr_gpio", a_gpio, {13'h1803, 13'h1FFF});
        chk("ovr_no_err", a_err, 1'b0);
        chk("ovr_no_autoload", a_busy, 1'b0);
        a_load_req = 1'b1;
        collect_a(stream, busy_n, load_at, done_at, bits);
        chk("reload_stream", stream, {13'h1803, 13'h1FFF});
        chk("reload_busy_cycles", busy_n, 53);
        chk("reload_done_cycle", done_at, 54);

        // Write and load request in the same IDLE cycle: snapshot holds the old word
        step();
        a_ovr_we = 1'b1; a_ovr_idx = 1'b1; a_ovr_data = 13'h0AAA; a_load_req = 1'b1;
        collect_a(stream, busy_n, load_at, done_at, bits);
        chk("same_cycle_stream", stream, {13'h1803, 13'h1FFF});
        chk("same_cycle_gpio", a_gpio, {13'h0AAA, 13'h1FFF});

        // Write while busy is rejected
        step();
        a_load_req = 1'b1;
        step();
        a_load_req = 1'b0;
        chk("busy_started", a_busy, 1'b1);
        step();
        a_ovr_we = 1'b1; a_ovr_idx = 1'b1; a_ovr_data = 13'h0000;
        step();
        a_ovr_we = 1'b0;
        chk("busy_wr_err", a_err, 1'b1);
        chk("busy_wr_gpio", a_gpio, {13'h0AAA, 13'h1FFF});
        step();
        chk("busy_err_pulse", a_err, 1'b0);
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            step();
            if (a_done) seen = 1;
        end
        chk("busy_load_done", seen, 1);

        // Reset asserted 20 cycles into a load
        step();
        a_load_req = 1'b1;
        repeat (20) begin
            step();
            a_load_req = 1'b0;
        end
        chk("mid_busy_before", a_busy, 1'b1);
        a_reset = 1'b1;
        #1;
        chk("mid_reset_outputs", {a_busy, a_sc, a_sd, a_sl, a_done, a_err}, 6'b0);
        chk("mid_reset_gpio", a_gpio, A_INIT);
        sl_seen = 0;
        repeat (3) begin
            step();
            if (a_sl || a_busy) sl_seen = 1;
        end
        chk("mid_reset_quiet", sl_seen, 0);
        a_reset = 1'b0;
        collect_a(stream, busy_n, load_at, done_at, bits);
        chk("restart_stream", stream, A_INIT);
        chk("restart_busy_cycles", busy_n, 53);
        chk("restart_load_cycle", load_at, 53);
        chk("restart_done_cycle", done_at, 54);

        // Slow serial clock, with a load request while busy
        begin
            bit prev = 1'b0;
            int first_rise = -1, first_fall = -1, rises = 0, hi_n = 0, done_n = 0, b_done_at = -1;
            logic [25:0] b_stream = '0;
            busy_n = 0;
            step();
            b_reset = 1'b0;
            for (int t = 1; t <= 300; t++) begin
                step();
                b_load_req = (t == 10);
                if (b_busy) busy_n++;
                if (b_sc) hi_n++;
                if (b_sc && !prev) begin
                    rises++;
                    b_stream = {b_stream[24:0], b_sd};
                    if (first_rise < 0) first_rise = t;
                end
                if (!b_sc && prev && first_fall < 0) first_fall = t;
                prev = b_sc;
                if (b_done) begin
                    done_n++;
                    b_done_at = t;
                end
            end
            chk("hp3_first_rise", first_rise, 4);
            chk("hp3_first_fall", first_fall, 7);
            chk("hp3_high_cycles", hi_n, 78);
            chk("hp3_rises", rises, 26);
            chk("hp3_stream", b_stream, B_INIT);
            chk("hp3_busy_cycles", busy_n, 157);
            chk("hp3_done_count", done_n, 1);
            chk("hp3_done_cycle", b_done_at, 158);
        end

        // Out-of-range index and a valid write to the top channel
        c_reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            step();
            if (c_done) seen = 1;
        end
        chk("c_load_done", seen, 1);
        step();
        c_ovr_we = 1'b1; c_ovr_idx = 2'd3; c_ovr_data = 13'h1FFF;
        step();
        c_ovr_we = 1'b0;
        chk("range_err", c_err, 1'b1);
        chk("range_gpio", c_gpio, C_INIT);
        c_ovr_we = 1'b1; c_ovr_idx = 2'd2; c_ovr_data = 13'h1234;
        step();
        c_ovr_we = 1'b0;
        chk("top_ch_err", c_err, 1'b0);
        chk("top_ch_gpio", c_gpio, {13'h1234, 13'h0402, 13'h0402});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
